// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit controller.
//   - lsu_state_e  : controller FSM encoding (IDLE, MEM, RESP)
//   - LB..SW       : RV32I load/store funct3 encodings
//   - DEFAULT_TIMEOUT_CYC : default mem_ack wait budget
//   - helpers for legality, alignment and store lane formatting
package lsu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 255;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    // funct3[1:0] carries the access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lsb);
        case (f3[1:0])
            2'b01:   return lsb[0];
            2'b10:   return lsb != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_we(input logic [2:0] f3, input logic [1:0] lsb);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lsb;
            2'b01:   return 4'b0011 << lsb;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the significant part across all lanes; byte enables pick the lane.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mask_n_shift.sv
// Load data extraction: selects the byte/halfword addressed by twolsb from a
// raw memory word and sign- or zero-extends it according to funct3.
//   twolsb        in  2   byte offset within the word
//   funct3        in  3   RV32I load funct3 (bit 2 = unsigned)
//   drdata        in  32  raw word from memory
//   sliced_drdata out 32  extended load result
module mask_n_shift (
    input  logic [1:0]  twolsb,
    input  logic [2:0]  funct3,
    input  logic [31:0] drdata,
    output logic [31:0] sliced_drdata
);

    logic [31:0] shifted;
    logic        sign_ext;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        sliced_drdata = drdata;
        shifted       = drdata >> {twolsb, 3'b000};
        sign_ext      = ~funct3[2];
        case (funct3[1:0])
            2'b00:   sliced_drdata = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            2'b01:   sliced_drdata = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: sliced_drdata = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core request at a time, issues a
// single word-aligned memory access (or rejects illegal/misaligned requests
// without touching memory), and returns a one-cycle response.
//   clk, reset    clock, synchronous active-high reset
//   req_*         core request handshake and fields (registered on accept)
//   mem_*         memory request held until mem_ack; mem_rdata valid with ack
//   resp_*        one-cycle completion pulse with load data and error flag
// TIMEOUT_CYC: MEM cycles without mem_ack before aborting (0 = wait forever).
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    // The abort fires in the MEM cycle whose increment would reach TIMEOUT_CYC,
    // so mem_req is high for exactly TIMEOUT_CYC cycles.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             store_q;
    logic [2:0]       f3_q;
    logic [1:0]       lsb_q;
    logic [3:0]       we_q;
    logic [31:0]      load_data;
    logic             accept;
    logic             req_ok;
    logic             timeout_hit;

    assign req_ready   = (state_q == IDLE) && !reset;
    assign accept      = req_valid && req_ready;
    assign req_ok      = f3_legal(req_is_store, funct3) && !misaligned(funct3, addr[1:0]);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    assign mem_req    = (state_q == MEM);
    assign mem_we     = mem_req ? we_q : 4'b0000;
    assign resp_valid = (state_q == RESP);

    mask_n_shift u_mask_n_shift (
        .twolsb        (lsb_q),
        .funct3        (f3_q),
        .drdata        (mem_rdata),
        .sliced_drdata (load_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = req_ok ? MEM : RESP;
            // mem_ack takes priority over a coincident timeout.
            MEM:  if (mem_ack || timeout_hit) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            store_q    <= 1'b0;
            f3_q       <= 3'b000;
            lsb_q      <= 2'b00;
            we_q       <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    store_q    <= req_is_store;
                    f3_q       <= funct3;
                    lsb_q      <= addr[1:0];
                    cnt_q      <= '0;
                    resp_rdata <= '0;
                    resp_err   <= !req_ok;
                    // Rejected requests leave the memory bus untouched.
                    if (req_ok) begin
                        mem_addr  <= {addr[31:2], 2'b00};
                        we_q      <= req_is_store ? store_we(funct3, addr[1:0]) : 4'b0000;
                        mem_wdata <= req_is_store ? store_data(funct3, wdata) : 32'h0;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        resp_rdata <= store_q ? 32'h0 : load_data;
                        resp_err   <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
